// File: rtl/dvd_pkg.sv
// dvd_pkg: shared defaults and helpers for the bouncing-logo motion block.
//   LOGO_SIZE_DEF / DISPLAY_WIDTH_DEF / DISPLAY_HEIGHT_DEF : geometry defaults
//   NUM_COLORS : length of the colour cycle (indices 0..NUM_COLORS-1)
//   POS_W      : width of a screen coordinate
//   NUM_AXES   : axes handled by the motion block (0 = X, 1 = Y)
package dvd_pkg;

   localparam int LOGO_SIZE_DEF      = 128;
   localparam int DISPLAY_WIDTH_DEF  = 640;
   localparam int DISPLAY_HEIGHT_DEF = 480;
   localparam int NUM_COLORS         = 7;
   localparam int POS_W              = 10;
   localparam int NUM_AXES           = 2;
   localparam int AX_X               = 0;
   localparam int AX_Y               = 1;

   // Colour index advance, wrapping back to 0 after the last colour.
   function automatic logic [2:0] next_color(input logic [2:0] c);
      return (c == 3'(NUM_COLORS - 1)) ? 3'd0 : c + 3'd1;
   endfunction

endpackage

// File: rtl/bounce_axis.sv
// bounce_axis: combinational one-axis step with wall reflection.
//   pos, dir   : current origin and direction (1 = increasing)
//   limit      : largest legal origin on this axis
//   step       : pixels to move this frame (1..4)
//   pos_nxt, dir_nxt : origin/direction after the step, clamped to [0, limit]
//   hit        : the step reached a wall and the direction flipped
module bounce_axis
   import dvd_pkg::*;
(
   input  logic [POS_W-1:0] pos,
   input  logic             dir,
   input  logic [POS_W-1:0] limit,
   input  logic [2:0]       step,
   output logic [POS_W-1:0] pos_nxt,
   output logic             dir_nxt,
   output logic             hit
);

   // One extra bit so pos + step can never wrap before the compare.
   logic [POS_W:0]   sum;
   logic [POS_W-1:0] step_w;

   assign step_w = {{(POS_W-3){1'b0}}, step};
   assign sum    = {1'b0, pos} + {1'b0, step_w};

   always_comb begin
      pos_nxt = pos;
      dir_nxt = dir;
      hit     = 1'b0;
      if (dir) begin
         if (sum >= {1'b0, limit}) begin
            pos_nxt = limit;
            dir_nxt = 1'b0;
            hit     = 1'b1;
         end else begin
            pos_nxt = sum[POS_W-1:0];
         end
      end else begin
         // Compare before subtracting so the origin cannot underflow.
         if (pos <= step_w) begin
            pos_nxt = '0;
            dir_nxt = 1'b1;
            hit     = 1'b1;
         end else begin
            pos_nxt = pos - step_w;
         end
      end
   end

endmodule

// File: rtl/logo_motion_ctrl.sv
// logo_motion_ctrl: moves a square logo once per video frame, bouncing off
// the screen edges and cycling its colour on every bounce.
//   clk, rst_n     : pixel clock, synchronous active-low reset
//   pix_y          : current scanline from the sync generator
//   enable         : 1 = move on each frame, 0 = freeze
//   speed          : step per frame is speed + 1 pixels
//   logo_left/top  : registered logo origin
//   color_idx      : registered colour index 0..6
//   bounce         : one-cycle pulse, some wall was hit this frame
//   corner_hit     : one-cycle pulse, both walls hit in the same frame
module logo_motion_ctrl
   import dvd_pkg::*;
#(
   parameter int LOGO_SIZE      = LOGO_SIZE_DEF,
   parameter int DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
   parameter int DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
   parameter int INIT_X         = 200,
   parameter int INIT_Y         = 200,
   parameter bit INIT_DIR_X     = 1'b1,
   parameter bit INIT_DIR_Y     = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [POS_W-1:0] pix_y,
   input  logic             enable,
   input  logic [1:0]       speed,
   output logic [POS_W-1:0] logo_left,
   output logic [POS_W-1:0] logo_top,
   output logic [2:0]       color_idx,
   output logic             bounce,
   output logic             corner_hit
);

   localparam logic [POS_W-1:0] X_MAX = POS_W'(DISPLAY_WIDTH  - LOGO_SIZE);
   localparam logic [POS_W-1:0] Y_MAX = POS_W'(DISPLAY_HEIGHT - LOGO_SIZE);
   localparam logic [NUM_AXES-1:0][POS_W-1:0] LIMIT    = {Y_MAX, X_MAX};
   localparam logic [NUM_AXES-1:0][POS_W-1:0] INIT_POS = {POS_W'(INIT_Y), POS_W'(INIT_X)};

   logic [POS_W-1:0]                prev_y;
   logic [NUM_AXES-1:0][POS_W-1:0]  pos_q, pos_nxt;
   logic [NUM_AXES-1:0]             dir_q, dir_nxt, hit;
   logic [2:0]                      step;
   logic                            tick, move;

   // Falling edge into line 0: fires once per frame however long pix_y sits at 0.
   assign tick = (pix_y == '0) && (prev_y != '0);
   assign move = tick && enable;
   assign step = {1'b0, speed} + 3'd1;

   for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
      bounce_axis u_axis (
         .pos     (pos_q[a]),
         .dir     (dir_q[a]),
         .limit   (LIMIT[a]),
         .step    (step),
         .pos_nxt (pos_nxt[a]),
         .dir_nxt (dir_nxt[a]),
         .hit     (hit[a])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_y     <= '0;
         pos_q      <= INIT_POS;
         dir_q      <= {INIT_DIR_Y, INIT_DIR_X};
         color_idx  <= '0;
         bounce     <= 1'b0;
         corner_hit <= 1'b0;
      end else begin
         prev_y     <= pix_y;
         bounce     <= 1'b0;
         corner_hit <= 1'b0;
         if (move) begin
            pos_q      <= pos_nxt;
            dir_q      <= dir_nxt;
            bounce     <= |hit;
            corner_hit <= &hit;
            // A corner counts as one bounce for the colour cycle.
            if (|hit)
               color_idx <= next_color(color_idx);
         end
      end
   end

   assign logo_left = pos_q[AX_X];
   assign logo_top  = pos_q[AX_Y];

endmodule

// File: doc/logo_motion_ctrl.md
LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

Interface
REQ-001 Parameter LOGO_SIZE, default 128: logo edge length in pixels.
REQ-002 Parameter DISPLAY_WIDTH, default 640: visible width; X_MAX = DISPLAY_WIDTH - LOGO_SIZE (512).
REQ-003 Parameter DISPLAY_HEIGHT, default 480: visible height; Y_MAX = DISPLAY_HEIGHT - LOGO_SIZE (352).
REQ-004 Parameters INIT_X = 200, INIT_Y = 200, INIT_DIR_X = 1, INIT_DIR_Y = 0: reset position and direction (1 = increasing).
REQ-005 clk  input  1  pixel clock.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 pix_y  input  10  current vertical position from the VGA sync generator.
REQ-008 enable  input  1  1 = motion runs; 0 = freeze.
REQ-009 speed  input  2  step per frame = speed + 1 pixels (1..4).
REQ-010 logo_left  output  10  logo X origin, registered.
REQ-011 logo_top  output  10  logo Y origin, registered.
REQ-012 color_idx  output  3  logo colour index, 0..6, registered.
REQ-013 bounce  output  1  one-cycle pulse: at least one wall hit this frame.
REQ-014 corner_hit  output  1  one-cycle pulse: both axes hit a wall in the same frame.

Function
REQ-015 prev_y SHALL register pix_y every cycle; frame tick = (pix_y == 0) && (prev_y != 0).
REQ-016 A frame tick SHALL fire once per frame, however long pix_y remains 0.
REQ-017 On a tick with enable = 0, position, direction, colour SHALL hold and no pulses SHALL fire.
REQ-018 On a tick with enable = 1, step = speed + 1, sampled on the tick cycle; results visible the following cycle.
REQ-019 X, dir_x = 1: if logo_left + step >= X_MAX then logo_left <= X_MAX, dir_x <= 0, hit_x; else logo_left <= logo_left + step.
REQ-020 X, dir_x = 0: if logo_left <= step then logo_left <= 0, dir_x <= 1, hit_x; else logo_left <= logo_left - step.
REQ-021 Y axis SHALL follow REQ-019/020 with logo_top, dir_y, Y_MAX, hit_y.
REQ-022 Position SHALL never leave [0, X_MAX] / [0, Y_MAX]; no 10-bit underflow or overflow.
REQ-023 On (hit_x | hit_y), color_idx SHALL advance by exactly 1, wrapping 6 -> 0, even when both axes hit.
REQ-024 bounce SHALL be high for exactly the cycle after a tick with hit_x | hit_y; corner_hit likewise for hit_x & hit_y.

Reset
REQ-025 With rst_n = 0 at a clk edge: logo_left = INIT_X, logo_top = INIT_Y, dir_x = INIT_DIR_X, dir_y = INIT_DIR_Y, color_idx = 0, bounce = 0, corner_hit = 0, prev_y = 0.
REQ-026 Reset mid-frame SHALL discard any pending update; the first tick after reset is the next 1-to-0 transition of pix_y (nonzero-to-0).

Structure
REQ-027 Package dvd_pkg SHALL hold LOGO_SIZE, DISPLAY_WIDTH, DISPLAY_HEIGHT defaults and the colour count (7).
REQ-028 One sub-module, bounce_axis (position, direction, limit, step -> next position, next direction, hit), SHALL be instantiated once per axis.
REQ-029 Tick detection, colour counter and pulse registers SHALL reside in logo_motion_ctrl.

Verification
REQ-030 Default params, speed = 0, enable = 1, 1 full frame (pix_y 0..524 -> 0) -> logo_left = 201, logo_top = 199, no bounce.
REQ-031 Default params, speed = 0, 312 ticks -> tick 200: logo_top = 0, dir_y = 1, bounce, color_idx = 1; tick 312: logo_left = 512, dir_x = 0, bounce, color_idx = 2, logo_top = 112.
REQ-032 INIT_X = 1, INIT_Y = 1, INIT_DIR_X = 0, INIT_DIR_Y = 0, speed = 3, 1 tick -> logo_left = 0, logo_top = 0, bounce = 1, corner_hit = 1, color_idx = 1.
REQ-033 enable = 0 for 10 frames, then 1 -> position unchanged for 10 frames, then moves 1 px per frame.
REQ-034 pix_y held at 0 for 2000 cycles -> one update only; rst_n low mid-frame -> outputs back to 200/200/0 next cycle.
REQ-035 Force 7 bounces -> color_idx sequence 1..6, then 0.
